// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Generates the PC, drives a synchronous instruction memory with a 1-cycle read
// latency, and presents {inst_out, pc_out} plus the register enable to the
// fetch/decode pipeline register. Handles start/halt sequencing, downstream
// stall and branch redirect with wrong-path squash.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start, start_pc   begin fetching at start_pc (only from IDLE/HALTED)
//   stall             downstream cannot accept; hold current instruction
//   redirect_valid/pc taken branch/jump target this cycle
//   imem_addr/en      memory read request (combinational)
//   imem_rdata        memory data for the address requested last cycle
//   inst_out, pc_out  instruction and its PC (inst_out=0 when !valid_out)
//   valid_out         inst_out is a real, non-squashed instruction
//   en_out            pipeline register enable (~stall)
//   halted            fetch stopped by a HALT opcode
//   fetch_count       instructions accepted downstream (wraps)
module fetch_unit #(
    parameter int         INST_ADDR_WIDTH = 9,
    parameter logic [5:0] HALT_OPCODE     = 6'h3F,
    parameter int         CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [INST_ADDR_WIDTH-1:0] start_pc,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr,
    output logic                       imem_en,
    input  logic [31:0]                imem_rdata,
    output logic [31:0]                inst_out,
    output logic [INST_ADDR_WIDTH-1:0] pc_out,
    output logic                       valid_out,
    output logic                       en_out,
    output logic                       halted,
    output logic [CNT_WIDTH-1:0]       fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                       state, state_nxt;
    logic [INST_ADDR_WIDTH-1:0]   req_pc, req_pc_nxt;
    logic                         rvalid, rvalid_nxt;
    logic                         halted_nxt;
    logic                         accept;
    logic                         is_halt;

    // Output side: what is currently on imem_rdata, qualified.
    always_comb begin
        valid_out = ~reset & (state == RUN) & rvalid & ~redirect_valid;
        accept    = valid_out & ~stall;
        is_halt   = accept & (imem_rdata[31:26] == HALT_OPCODE);
        inst_out  = valid_out ? imem_rdata : 32'd0;
        pc_out    = reset ? '0 : req_pc;
        en_out    = ~stall;
    end

    // Next-state and request side.
    always_comb begin
        state_nxt  = state;
        req_pc_nxt = req_pc;
        rvalid_nxt = rvalid;
        halted_nxt = halted;
        imem_en    = 1'b0;
        imem_addr  = req_pc;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        imem_en   = 1'b1;
                        imem_addr = redirect_pc;
                    end else if (is_halt) begin
                        rvalid_nxt = 1'b0;
                        halted_nxt = 1'b1;
                        state_nxt  = HALTED;
                    end else if (stall) begin
                        // Re-read the same word so rdata/pc_out stay stable.
                        imem_en   = 1'b1;
                        imem_addr = req_pc;
                    end else begin
                        imem_en   = 1'b1;
                        imem_addr = req_pc + 1'b1;
                    end
                    if (imem_en) begin
                        req_pc_nxt = imem_addr;
                        rvalid_nxt = 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        imem_en    = 1'b1;
                        imem_addr  = start_pc;
                        req_pc_nxt = start_pc;
                        rvalid_nxt = 1'b1;
                        halted_nxt = 1'b0;
                        state_nxt  = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_pc      <= '0;
            rvalid      <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state  <= state_nxt;
            req_pc <= req_pc_nxt;
            rvalid <= rvalid_nxt;
            halted <= halted_nxt;
            if (accept)
                fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule
